// File: rtl/interpolation_ram_engine.sv
// Data RAM with a linear-interpolation engine for the ODE solver.
// The host reads/writes the RAM directly. An init pass latches the problem
// header, and an interpolation pass writes U(T) back to words 403+i.

// 16-bit carry-lookahead adder/subtractor; Invalid flags signed overflow.
module interp_cla16 (
    input  logic        Sub,
    input  logic        Cin,
    input  logic [15:0] In1,
    input  logic [15:0] In2,
    output logic [15:0] Out,
    output logic        Cout,
    output logic        Invalid
);
    logic [15:0] b_eff, g, p;
    logic [16:0] c;

    assign b_eff = Sub ? ~In2 : In2;
    assign g     = In1 & b_eff;
    assign p     = In1 ^ b_eff;

    // Carry chain from per-bit generate/propagate terms.
    always_comb begin
        c[0] = Cin ^ Sub;
        for (int k = 0; k < 16; k++)
            c[k+1] = g[k] | (p[k] & c[k]);
    end

    assign Out     = p ^ c[15:0];
    assign Cout    = c[16];
    assign Invalid = c[16] ^ c[15];
endmodule

module interpolation_ram_engine #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Interpolation_Enable,
    input  logic                     Interpolation_Intialize,
    input  logic [ADDRESS_WIDTH-1:0] RAM_WR_Address,
    input  logic [DATA_WIDTH-1:0]    RAM_WR_Data,
    input  logic [ADDRESS_WIDTH-1:0] RAM_RD1_Address,
    output logic [DATA_WIDTH-1:0]    RAM_RD1_Data,
    input  logic [ADDRESS_WIDTH-1:0] RAM_RD2_Address,
    output logic [DATA_WIDTH-1:0]    RAM_RD2_Data,
    input  logic                     Memory_RD_Enable,
    input  logic                     Memory_WR_Enable,
    output logic                     Interpolation_Done,
    output logic                     Intialization_Done,
    output logic                     Error,
    output logic [3:0]               current_intialization_state,
    output logic [3:0]               current_interpolation_state
);
    localparam int MEM_DEPTH = 1 << ADDRESS_WIDTH;

    localparam logic [3:0] I_IDLE = 4'd0, I_READ_HDR = 4'd1, I_CHECK = 4'd2, I_DONE = 4'd3;
    localparam logic [3:0] P_IDLE = 4'd0, P_LOCATE = 4'd1, P_READ = 4'd2, P_CALC = 4'd3,
                           P_WRITE = 4'd4, P_NEXT = 4'd5, P_DONE = 4'd6, P_ERROR = 4'd7;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    logic [3:0]  init_state, init_next, intp_state, intp_next;
    logic [2:0]  hdr_cnt;
    logic [15:0] hdr_t, hdr_m, hdr_n, hdr_s, hdr_t0;
    logic        hdr_bad, err_q;
    logic [15:0] seg_j, seg_f, elem_i, u_lo, u_hi, uk;
    logic        both_idle, init_go, intp_go, eng_we, hdr_check_bad;

    logic [2:0]  s3;
    logic [15:0] a_in1, a_in2, a_out, b_out, q, j_sel, f_sel, step;
    logic        a_cout, a_inv, b_cout, b_inv, loc_err, calc_err;
    logic signed [31:0] prod;
    logic [ADDRESS_WIDTH-1:0] lo_addr, hi_addr, out_addr;
    logic        unused_carry;

    assign both_idle = (init_state == I_IDLE) && (intp_state == P_IDLE);
    // Initialization wins when both pulses arrive together.
    assign init_go   = both_idle && Interpolation_Intialize;
    assign intp_go   = both_idle && Interpolation_Enable && !Interpolation_Intialize;
    assign s3        = hdr_s[2:0];

    // Adder A: T - t0 while locating, U_{j+1} - U_j while calculating.
    assign a_in1 = (intp_state == P_LOCATE) ? hdr_t  : u_hi;
    assign a_in2 = (intp_state == P_LOCATE) ? hdr_t0 : u_lo;
    interp_cla16 u_add_a (.Sub(1'b1), .Cin(1'b0), .In1(a_in1), .In2(a_in2),
                          .Out(a_out), .Cout(a_cout), .Invalid(a_inv));

    // Segment index; q == M-1 (T on the last sample) folds into segment M-2 with f = h.
    assign q       = a_out >> s3;
    assign loc_err = a_out[15] | a_inv | (q >= hdr_m);
    assign j_sel   = (q + 16'd1 >= hdr_m) ? hdr_m - 16'd2 : q;
    assign f_sel   = a_out - (j_sel << s3);

    // Slope * f scaled back by h, then added to U_j on adder B.
    assign prod = 32'($signed(a_out)) * 32'($signed(seg_f));
    assign step = 16'(prod >>> s3);
    interp_cla16 u_add_b (.Sub(1'b0), .Cin(1'b0), .In1(u_lo), .In2(step),
                          .Out(b_out), .Cout(b_cout), .Invalid(b_inv));
    assign calc_err     = a_inv | b_inv;
    assign unused_carry = a_cout ^ b_cout;

    assign lo_addr  = ADDRESS_WIDTH'(16'd103 + (seg_j << 3) + elem_i);
    assign hi_addr  = lo_addr + ADDRESS_WIDTH'(8);
    assign out_addr = ADDRESS_WIDTH'(16'd403 + elem_i);

    assign hdr_check_bad = (hdr_m < 16'd2) || (hdr_m > 16'd8) || (hdr_n == 16'd0) || (hdr_s > 16'd7);

    // Host read ports: combinational, gated by the read enable.
    assign RAM_RD1_Data = Memory_RD_Enable ? mem[RAM_RD1_Address] : '0;
    assign RAM_RD2_Data = Memory_RD_Enable ? mem[RAM_RD2_Address] : '0;

    assign current_intialization_state = init_state;
    assign current_interpolation_state = intp_state;
    assign Error = err_q;

    // Init FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) init_state <= I_IDLE;
        else     init_state <= init_next;
    end

    // Init FSM next-state logic.
    always_comb begin
        init_next = init_state;
        case (init_state)
            I_IDLE:     if (init_go) init_next = I_READ_HDR;
            I_READ_HDR: if (hdr_cnt == 3'd4) init_next = I_CHECK;
            I_CHECK:    init_next = I_DONE;
            I_DONE:     init_next = I_IDLE;
            default:    init_next = I_IDLE;
        endcase
    end

    // Init FSM outputs.
    always_comb begin
        Intialization_Done = (init_state == I_DONE);
    end

    // Interpolation FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) intp_state <= P_IDLE;
        else     intp_state <= intp_next;
    end

    // Interpolation FSM next-state logic.
    always_comb begin
        intp_next = intp_state;
        case (intp_state)
            P_IDLE:   if (intp_go) intp_next = hdr_bad ? P_ERROR : P_LOCATE;
            P_LOCATE: intp_next = loc_err ? P_ERROR : P_READ;
            P_READ:   intp_next = P_CALC;
            P_CALC:   intp_next = calc_err ? P_ERROR : P_WRITE;
            P_WRITE:  intp_next = P_NEXT;
            P_NEXT:   intp_next = (elem_i + 16'd1 < hdr_n) ? P_READ : P_DONE;
            P_DONE:   intp_next = P_IDLE;
            P_ERROR:  intp_next = P_IDLE;
            default:  intp_next = P_IDLE;
        endcase
    end

    // Interpolation FSM outputs.
    always_comb begin
        Interpolation_Done = (intp_state == P_DONE) || (intp_state == P_ERROR);
        eng_we             = (intp_state == P_WRITE);
    end

    // Header latch, per-element datapath and the sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hdr_cnt <= '0; hdr_t <= '0; hdr_m <= '0; hdr_n <= '0; hdr_s <= '0; hdr_t0 <= '0;
            hdr_bad <= 1'b0; err_q <= 1'b0;
            seg_j <= '0; seg_f <= '0; elem_i <= '0; u_lo <= '0; u_hi <= '0; uk <= '0;
        end else begin
            if (init_go) begin
                err_q   <= 1'b0;
                hdr_bad <= 1'b0;
                hdr_cnt <= '0;
            end
            if (intp_go) begin
                err_q  <= 1'b0;
                elem_i <= '0;
            end
            if (init_state == I_READ_HDR) begin
                case (hdr_cnt)
                    3'd0:    hdr_t  <= mem[ADDRESS_WIDTH'(hdr_cnt)][15:0];
                    3'd1:    hdr_m  <= mem[ADDRESS_WIDTH'(hdr_cnt)][15:0];
                    3'd2:    hdr_n  <= mem[ADDRESS_WIDTH'(hdr_cnt)][15:0];
                    3'd3:    hdr_s  <= mem[ADDRESS_WIDTH'(hdr_cnt)][15:0];
                    default: hdr_t0 <= mem[ADDRESS_WIDTH'(hdr_cnt)][15:0];
                endcase
                hdr_cnt <= hdr_cnt + 3'd1;
            end
            if (init_state == I_CHECK && hdr_check_bad) begin
                hdr_bad <= 1'b1;
                err_q   <= 1'b1;
            end
            if (intp_state == P_LOCATE) begin
                seg_j <= j_sel;
                seg_f <= f_sel;
            end
            if (intp_state == P_READ) begin
                u_lo <= mem[lo_addr][15:0];
                u_hi <= mem[hi_addr][15:0];
            end
            if (intp_state == P_CALC) uk <= b_out;
            if (intp_state == P_NEXT) elem_i <= elem_i + 16'd1;
            // Raised on entry so Error is already high during the Done pulse.
            if (intp_next == P_ERROR) err_q <= 1'b1;
        end
    end

    // RAM write port: engine results take precedence; host writes only when idle.
    always_ff @(posedge CLK) begin
        if (!RST && eng_we)
            mem[out_addr] <= {{(DATA_WIDTH-16){uk[15]}}, uk};
        else if (!RST && Memory_WR_Enable && both_idle)
            mem[RAM_WR_Address] <= RAM_WR_Data;
    end
endmodule

// File: tb/tb_interpolation_ram_engine.sv
// Directed bench for interpolation_ram_engine with hand-computed results.
module tb_interpolation_ram_engine;
    localparam int AW = 13;
    localparam int DW = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Interpolation_Enable, Interpolation_Intialize;
    logic [AW-1:0] RAM_WR_Address, RAM_RD1_Address, RAM_RD2_Address;
    logic [DW-1:0] RAM_WR_Data, RAM_RD1_Data, RAM_RD2_Data;
    logic          Memory_RD_Enable, Memory_WR_Enable;
    logic          Interpolation_Done, Intialization_Done, Error;
    logic [3:0]    current_intialization_state, current_interpolation_state;

    int n_tests = 0;
    int n_fail  = 0;

    interpolation_ram_engine #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .Interpolation_Enable(Interpolation_Enable),
        .Interpolation_Intialize(Interpolation_Intialize),
        .RAM_WR_Address(RAM_WR_Address), .RAM_WR_Data(RAM_WR_Data),
        .RAM_RD1_Address(RAM_RD1_Address), .RAM_RD1_Data(RAM_RD1_Data),
        .RAM_RD2_Address(RAM_RD2_Address), .RAM_RD2_Data(RAM_RD2_Data),
        .Memory_RD_Enable(Memory_RD_Enable), .Memory_WR_Enable(Memory_WR_Enable),
        .Interpolation_Done(Interpolation_Done), .Intialization_Done(Intialization_Done),
        .Error(Error),
        .current_intialization_state(current_intialization_state),
        .current_interpolation_state(current_interpolation_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr16(input int addr, input logic [15:0] v);
        RAM_WR_Address   = AW'(addr);
        RAM_WR_Data      = sx(v);
        Memory_WR_Enable = 1'b1;
        @(posedge CLK); #1;
        Memory_WR_Enable = 1'b0;
    endtask

    task automatic rd(input int addr, output logic [63:0] v);
        RAM_RD1_Address  = AW'(addr);
        Memory_RD_Enable = 1'b1;
        #1;
        v = RAM_RD1_Data;
        Memory_RD_Enable = 1'b0;
    endtask

    task automatic set_hdr(input logic [15:0] t, m, n, s, t0);
        wr16(0, t); wr16(1, m); wr16(2, n); wr16(3, s); wr16(4, t0);
    endtask

    task automatic do_init(output logic err);
        int k;
        Interpolation_Intialize = 1'b1;
        @(posedge CLK); #1;
        Interpolation_Intialize = 1'b0;
        k = 0;
        while (!Intialization_Done && k < 20) begin @(posedge CLK); #1; k++; end
        chk("init_done_seen", Intialization_Done, 1'b1);
        err = Error;
        @(posedge CLK); #1;
        chk("init_done_one_cycle", Intialization_Done, 1'b0);
    endtask

    task automatic wait_interp(output logic err, output logic [3:0] st);
        int k;
        k = 0;
        while (!Interpolation_Done && k < 100) begin @(posedge CLK); #1; k++; end
        chk("interp_done_seen", Interpolation_Done, 1'b1);
        err = Error;
        st  = current_interpolation_state;
        @(posedge CLK); #1;
        chk("interp_done_one_cycle", Interpolation_Done, 1'b0);
    endtask

    task automatic start_interp;
        Interpolation_Enable = 1'b1;
        @(posedge CLK); #1;
        Interpolation_Enable = 1'b0;
    endtask

    initial begin
        logic [63:0] v;
        logic        err;
        logic [3:0]  st;
        int          k;

        RST = 1'b1;
        Interpolation_Enable = 0; Interpolation_Intialize = 0;
        RAM_WR_Address = '0; RAM_WR_Data = '0;
        RAM_RD1_Address = '0; RAM_RD2_Address = '0;
        Memory_RD_Enable = 0; Memory_WR_Enable = 0;
        repeat (2) @(posedge CLK); #1;
        chk("rst_init_state", current_intialization_state, 4'd0);
        chk("rst_interp_state", current_interpolation_state, 4'd0);
        chk("rst_error", Error, 1'b0);
        chk("rst_dones", {Intialization_Done, Interpolation_Done}, 2'b00);
        RST = 1'b0;

        // Host traffic: combinational dual read, enable gating.
        set_hdr(16, 3, 3, 4, 0);
        wr16(0, 16'h2002);
        RAM_RD1_Address = 0; RAM_RD2_Address = 2; Memory_RD_Enable = 1'b1; #1;
        chk("host_rd1", RAM_RD1_Data, 64'h2002);
        chk("host_rd2", RAM_RD2_Data, 64'd3);
        Memory_RD_Enable = 1'b0; #1;
        chk("host_rd1_off", RAM_RD1_Data, 64'd0);
        chk("host_rd2_off", RAM_RD2_Data, 64'd0);
        @(posedge CLK); #1;

        // Exact sample hit: T = h with M = 3 gives j = 1, f = 0.
        wr16(0, 16);
        wr16(103, 1); wr16(104, 2); wr16(105, 3);
        wr16(111, 5); wr16(112, 16'hFFF9); wr16(113, 100);
        wr16(119, 9); wr16(120, 9); wr16(121, 9);
        do_init(err);
        chk("hit_init_err", err, 1'b0);
        start_interp;
        wait_interp(err, st);
        chk("hit_err", err, 1'b0);
        chk("hit_state", st, 4'd6);
        rd(403, v); chk("hit_uk0", v, sx(5));
        rd(404, v); chk("hit_uk1", v, sx(16'hFFF9));
        rd(405, v); chk("hit_uk2", v, sx(100));

        // Last sample exactly: T = t0 + (M-1)h gives U_2.
        wr16(0, 32);
        do_init(err);
        start_interp;
        wait_interp(err, st);
        chk("edge_err", err, 1'b0);
        rd(403, v); chk("edge_uk0", v, sx(9));
        rd(404, v); chk("edge_uk1", v, sx(9));
        rd(405, v); chk("edge_uk2", v, sx(9));

        // Midpoint, plus a host write attempted while busy.
        wr16(500, 16'h0055);
        set_hdr(8, 2, 2, 4, 0);
        wr16(103, 0); wr16(104, 10); wr16(111, 16); wr16(112, 16'hFFF6);
        do_init(err);
        start_interp;
        wr16(500, 16'h0BAD);
        wait_interp(err, st);
        chk("mid_err", err, 1'b0);
        rd(403, v); chk("mid_uk0", v, sx(8));
        rd(404, v); chk("mid_uk1", v, sx(0));
        rd(500, v); chk("busy_write_ignored", v, sx(16'h0055));

        // Nonzero t0, h = 4: d = 7, j = 1, f = 3; second element floors -21/4 to -6.
        set_hdr(107, 4, 2, 2, 100);
        wr16(111, 16'hFFEC); wr16(112, 10); wr16(119, 20); wr16(120, 3);
        do_init(err);
        start_interp;
        wait_interp(err, st);
        chk("off_err", err, 1'b0);
        rd(403, v); chk("off_uk0", v, sx(10));
        rd(404, v); chk("off_uk1", v, sx(4));

        // Out of range below: T = t0 - 1.
        wr16(0, 99);
        do_init(err);
        chk("oor_init_err", err, 1'b0);
        start_interp;
        wait_interp(err, st);
        chk("oor_err", err, 1'b1);
        chk("oor_state", st, 4'd7);
        rd(403, v); chk("oor_uk0_kept", v, sx(10));

        // Re-init with valid T clears Error.
        wr16(0, 107);
        do_init(err);
        chk("reinit_clears_err", err, 1'b0);

        // Out of range above: d >> S = 4 > M-1.
        wr16(0, 116);
        do_init(err);
        start_interp;
        wait_interp(err, st);
        chk("oor_hi_err", err, 1'b1);
        rd(403, v); chk("oor_hi_uk0_kept", v, sx(10));

        // Bad header: N = 0.
        set_hdr(107, 4, 0, 2, 100);
        do_init(err);
        chk("badhdr_init_err", err, 1'b1);
        start_interp;
        chk("badhdr_goes_error", current_interpolation_state, 4'd7);
        wait_interp(err, st);
        chk("badhdr_interp_err", err, 1'b1);
        rd(403, v); chk("badhdr_no_write", v, sx(10));

        // Both pulses together: init wins, Enable dropped.
        wr16(2, 2);
        Interpolation_Intialize = 1'b1; Interpolation_Enable = 1'b1;
        @(posedge CLK); #1;
        Interpolation_Intialize = 1'b0; Interpolation_Enable = 1'b0;
        chk("both_init_state", current_intialization_state, 4'd1);
        chk("both_interp_state", current_interpolation_state, 4'd0);
        k = 0;
        while (!Intialization_Done && k < 20) begin @(posedge CLK); #1; k++; end
        chk("both_init_done", Intialization_Done, 1'b1);
        chk("both_init_err", Error, 1'b0);
        @(posedge CLK); #1;
        chk("both_interp_idle", current_interpolation_state, 4'd0);

        // Reset during CALC: nothing further written, old contents intact.
        wr16(111, 0); wr16(119, 40);
        do_init(err);
        start_interp;
        k = 0;
        while (current_interpolation_state != 4'd3 && k < 20) begin @(posedge CLK); #1; k++; end
        chk("rst_reached_calc", current_interpolation_state, 4'd3);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_init_state", current_intialization_state, 4'd0);
        chk("midrst_interp_state", current_interpolation_state, 4'd0);
        chk("midrst_flags", {Interpolation_Done, Intialization_Done, Error}, 3'b000);
        RST = 1'b0;
        repeat (10) @(posedge CLK); #1;
        rd(403, v); chk("midrst_uk0_kept", v, sx(10));
        rd(404, v); chk("midrst_uk1_kept", v, sx(4));
        rd(0, v);   chk("midrst_hdr_kept", v, sx(107));
        rd(111, v); chk("midrst_sample_kept", v, sx(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/interpolation_ram_engine.md
Name: interpolation_ram_engine

Overview:
- 8K x 64 dual-read/single-write data RAM with a built-in linear-interpolation engine for the ODE solver.
- An initialization pass latches the problem header (current time, sample count, vector size, time grid) from RAM.
- An interpolation pass computes the solution vector U(T) from stored samples and writes it back to the RAM for the host to read.
- Arithmetic uses a 16-bit carry-lookahead adder/subtractor submodule (Sub, Cin, In1, In2 -> Out, Cout, Invalid; Invalid = signed overflow).

Parameters:
- ADDRESS_WIDTH, 13, RAM address width (8192 words).
- DATA_WIDTH, 64, RAM word width; numeric values are signed 16-bit in bits [15:0], upper bits written as sign extension.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- Interpolation_Enable  in  1  one-cycle start pulse for the interpolation pass.
- Interpolation_Intialize  in  1  one-cycle start pulse for the initialization pass.
- RAM_WR_Address  in  ADDRESS_WIDTH  host write address.
- RAM_WR_Data  in  DATA_WIDTH  host write data.
- RAM_RD1_Address  in  ADDRESS_WIDTH  host read port 1 address.
- RAM_RD1_Data  out  DATA_WIDTH  host read port 1 data.
- RAM_RD2_Address  in  ADDRESS_WIDTH  host read port 2 address.
- RAM_RD2_Data  out  DATA_WIDTH  host read port 2 data.
- Memory_RD_Enable  in  1  host read enable, both ports.
- Memory_WR_Enable  in  1  host write enable.
- Interpolation_Done  out  1  one-cycle pulse at end of interpolation pass.
- Intialization_Done  out  1  one-cycle pulse at end of initialization pass.
- Error  out  1  sticky error flag, cleared by reset or by the next start pulse.
- current_intialization_state  out  4  init FSM state code.
- current_interpolation_state  out  4  interpolation FSM state code.

Behaviour:
- Memory map (word addresses):
  - 0: T, current time.
  - 1: M, number of samples (2..8).
  - 2: N, vector size (1..7).
  - 3: S, time-step exponent; step h = 2^S, S in 0..7.
  - 4: t0, first sample time.
  - 103 + 8*j + i: sample U_j[i].
  - 403 + i: output UK[i].
- Host reads:
  - Combinational: RD_Data = RAM[RD_Address] while Memory_RD_Enable = 1, else 0.
  - Available at any time, including while the engine is busy.
- Host writes:
  - Synchronous: RAM[WR_Address] <= WR_Data on a rising edge with Memory_WR_Enable = 1.
  - Ignored while either FSM is non-idle.
- Reset:
  - Both FSMs go to 0; all outputs go to 0; latched header cleared.
  - RAM contents are preserved.
  - Reset has priority over simultaneous start pulses and aborts any pass mid-operation without further RAM writes.
- Init FSM:
  - 0 IDLE -> 1 on Interpolation_Intialize.
  - 1 READ_HDR: read words 0..4 over 5 cycles.
  - 2 CHECK: Error = 1 if M < 2, M > 8, N = 0, or S > 7.
  - 3 DONE: Intialization_Done = 1 for one cycle; return to 0.
  - Latency from pulse to Done: 7 cycles.
- Interpolation FSM:
  - 0 IDLE -> 1 on Interpolation_Enable.
  - If Error is set from init, go straight to 7.
  - 1 LOCATE:
    - d = T - t0 via adder (Sub = 1).
    - Error if d < 0, Invalid = 1, or (d >> S) > M - 1.
    - j = d >> S, clamped to M - 2.
    - f = d - (j << S).
  - 2 READ: fetch U_j[i] and U_{j+1}[i] on internal ports.
  - 3 CALC: UK[i] = U_j[i] + ((U_{j+1}[i] - U_j[i]) * f) >>> S.
    - Use a 32-bit signed product and arithmetic shift, truncated to 16 bits.
    - Adder overflow sets Error.
  - 4 WRITE: RAM[403 + i] <= UK[i], sign-extended.
  - 5 NEXT: i++; back to 2 if i < N, else 6.
  - 6 DONE: Interpolation_Done = 1 for one cycle -> 0.
  - 7 ERROR: Error = 1, Interpolation_Done = 1 for one cycle, no RAM writes -> 0.
- Start pulse while busy: ignored.
- Both start pulses in the same cycle: initialization wins; the Enable pulse is dropped.
- T exactly on t0 + (M-1)h: j = M-2, f = h, UK = U_{M-1} (no Error).
- State outputs are the FSM codes above, updated each cycle.

Test Plan:
- Exact sample hit:
  - Setup: T = 0x0010, t0 = 0, S = 4, M = 3, N = 3, U_1 = {5, -7, 100}.
  - Sequence: init then interp.
  - Required: RAM[403..405] = {5, -7, 100}; Done pulses once; Error = 0.
- Midpoint:
  - Setup: T = 8, t0 = 0, S = 4, U_0 = {0, 10}, U_1 = {16, -10}, N = 2.
  - Required: RAM[403..404] = {8, 0}.
- Out of range:
  - Setup: T = t0 - 1.
  - Required: Error = 1; Interpolation_Done pulses; RAM[403] unchanged.
  - Then: re-init with valid T clears Error.
- Bad header:
  - Setup: N = 0.
  - Required: Intialization_Done pulses with Error = 1; interpolation pass goes to state 7 with no writes.
- Host traffic:
  - Write 0x2002 to address 0, then read ports 1/2 at addresses 0 and 2.
  - Required: same-cycle combinational data 0x2002 and N; RD_Enable = 0 gives 0.
- Reset mid-pass:
  - Assert RST during state 3.
  - Required: next cycle both state outputs are 0, Done/Error are 0, no further RAM writes, earlier RAM contents intact.
